// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared types and constants for the 4:1 round-robin arbitrating mux.
//   ch_idx_t  - 2-bit channel index
//   NUM_CH    - number of input channels
//   RST_LAST  - last-grant pointer value after reset (makes channel 0 first)
package arb_mux_pkg;
  localparam int NUM_CH = 4;
  typedef logic [1:0] ch_idx_t;
  localparam ch_idx_t RST_LAST = 2'd3;
endpackage

// File: rtl/rr_pick_4.sv
// rr_pick_4: combinational round-robin picker.
//   vld     in  [NUM_CH]  per-channel request
//   last    in  ch_idx_t  most recently granted channel
//   winner  out ch_idx_t  first set request searching from last+1, wrapping
//   any_vld out 1         at least one request set
module rr_pick_4
  import arb_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] vld,
  input  ch_idx_t           last,
  output ch_idx_t           winner,
  output logic              any_vld
);

  // Walk from lowest priority (last itself) to highest (last+1) so the
  // highest-priority set request is the final assignment.
  always_comb begin
    winner  = last;
    any_vld = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      ch_idx_t idx;
      idx = last + ch_idx_t'(k);
      if (vld[idx]) begin
        winner  = idx;
        any_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_4_1.sv
// arb_mux_4_1: 4-input round-robin arbiter feeding a single registered
// output stage with valid/ready handshakes on both sides.
//   clk, rst         clock, synchronous active-high reset
//   d0..d3, vld      channel data and requests
//   rdy              one-hot (or zero) accept back to the channels
//   out_data/sel/vld registered output word, its source channel, valid
//   out_rdy          downstream accept
module arb_mux_4_1
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  d0,
  input  logic [WIDTH-1:0]  d1,
  input  logic [WIDTH-1:0]  d2,
  input  logic [WIDTH-1:0]  d3,
  input  logic [NUM_CH-1:0] vld,
  output logic [NUM_CH-1:0] rdy,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        out_sel,
  output logic              out_vld,
  input  logic              out_rdy
);

  logic [NUM_CH-1:0][WIDTH-1:0] din;
  ch_idx_t last;
  ch_idx_t winner;
  logic    any_vld;
  logic    load_en;

  assign din = {d3, d2, d1, d0};

  // Output register can take a word when empty or draining this cycle.
  assign load_en = !out_vld || out_rdy;

  rr_pick_4 u_pick (
    .vld     (vld),
    .last    (last),
    .winner  (winner),
    .any_vld (any_vld)
  );

  // Reset gates the grant so no channel believes it transferred.
  always_comb begin
    rdy = '0;
    if (load_en && any_vld && !rst) rdy[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_sel  <= '0;
      last     <= RST_LAST;
    end else if (load_en) begin
      if (any_vld) begin
        out_data <= din[winner];
        out_sel  <= winner;
        out_vld  <= 1'b1;
        last     <= winner;
      end else begin
        // Data and pointer kept; only the valid flag drops.
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_4_1.sv
module tb_arb_mux_4_1;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]   vld = '0;
  logic [3:0]   rdy;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_vld;
  logic         out_rdy = 1'b0;

  int ncmp = 0;
  int nerr = 0;

  // reference model state
  logic         m_vld  = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_sel  = 0;
  int           m_last = 3;

  arb_mux_4_1 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .vld(vld), .rdy(rdy), .out_data(out_data), .out_sel(out_sel),
    .out_vld(out_vld), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] din(input int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  // Search channels in order last+1, last+2, ... (mod 4); -1 if none.
  function automatic int m_winner();
    for (int k = 1; k <= 4; k++)
      if (vld[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_rdy();
    int w;
    w = m_winner();
    if (rst) return 4'b0;
    if (m_vld && !out_rdy) return 4'b0;
    if (w < 0) return 4'b0;
    return 4'(1 << w);
  endfunction

  task automatic m_step();
    int w;
    w = m_winner();
    if (rst) begin
      m_vld = 1'b0; m_data = '0; m_sel = 0; m_last = 3;
    end else if (!m_vld || out_rdy) begin
      if (w >= 0) begin
        m_data = din(w); m_sel = w; m_vld = 1'b1; m_last = w;
      end else m_vld = 1'b0;
    end
  endtask

  // Inputs are set just after a rising edge; check rdy, clock, check outputs.
  task automatic cycle();
    logic [3:0] er;
    #1;
    er = m_rdy();
    chk("rdy", 32'(rdy), 32'(er));
    @(posedge clk);
    m_step();
    #1;
    chk("out_vld", 32'(out_vld), 32'(m_vld));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = '0; out_rdy = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;

    // reset state
    do_reset();
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);

    // single request on channel 0
    vld = 4'b0001; d0 = 4'hA; out_rdy = 1'b1;
    #1 chk("r028_rdy", 32'(rdy), 32'b0001);
    cycle();
    chk("r028_data", 32'(out_data), 32'hA);
    chk("r028_sel", 32'(out_sel), 32'd0);

    // all requesting: strict rotation 0,1,2,3,0
    do_reset();
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4; vld = 4'b1111; out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("r029_sel", 32'(out_sel), 32'(i % 4));
      chk("r029_data", 32'(out_data), 32'((i % 4) + 1));
    end

    // backpressure holds the word and blocks grants
    do_reset();
    vld = 4'b0001; d0 = 4'h5; out_rdy = 1'b1;
    cycle();
    vld = 4'b0110; d1 = 4'h7; d2 = 4'h9; out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("r030_rdy_stall", 32'(rdy), 32'd0);
      cycle();
      chk("r030_hold", 32'(out_data), 32'h5);
    end
    out_rdy = 1'b1;
    #1 chk("r030_rdy_go", 32'(rdy), 32'b0010);
    cycle();
    chk("r030_new", 32'(out_data), 32'h7);

    // wrap from channel 3 back to channel 0
    do_reset();
    vld = 4'b1000; d3 = 4'hC; d0 = 4'h3; out_rdy = 1'b1;
    cycle();
    chk("r031_g3", 32'(out_sel), 32'd3);
    vld = 4'b1001;
    cycle();
    chk("r031_g0", 32'(out_sel), 32'd0);

    // reset during stall discards the word
    vld = 4'b0100; d2 = 4'hE; out_rdy = 1'b1;
    cycle();
    out_rdy = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("r032_vld", 32'(out_vld), 32'd0);
    chk("r032_data", 32'(out_data), 32'd0);
    rst = 1'b0; vld = 4'b1010; d1 = 4'h6; out_rdy = 1'b1;
    cycle();
    chk("r032_first", 32'(out_sel), 32'd1);

    // no request after a valid word: valid drops, data kept
    vld = 4'b0000;
    cycle();
    chk("r033_vld", 32'(out_vld), 32'd0);
    chk("r033_data", 32'(out_data), 32'h6);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      vld = 4'($urandom);
      d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom); d3 = W'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/arb_mux_4_1.md
ARB_MUX_4_1 -- requirements
Module: arb_mux_4_1

Interface
REQ-001 Parameter: WIDTH, default 4, data width of each input channel and of the output.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 d0, d1, d2, d3  input  WIDTH each  channel data.
REQ-005 vld  input  4  per-channel request; bit i qualifies di.
REQ-006 rdy  output  4  per-channel accept; transfer on channel i when vld[i] && rdy[i] in the same cycle.
REQ-007 out_data  output  WIDTH  registered data of the selected channel.
REQ-008 out_sel  output  2  registered index of the channel held in out_data.
REQ-009 out_vld  output  1  out_data/out_sel hold a valid word.
REQ-010 out_rdy  input  1  downstream accept; transfer when out_vld && out_rdy.

Function
REQ-011 load_en = !out_vld || out_rdy; new word accepted only when load_en is 1.
REQ-012 rdy is combinational: at most one bit high (one-hot or zero); rdy[i] = load_en && (i is the round-robin winner among set vld bits).
REQ-013 Round-robin: priority order starts at (last + 1) mod 4 and wraps 3->0; last = index of most recent granted channel.
REQ-014 When load_en and any vld set: on clock edge out_data <= d[winner], out_sel <= winner, out_vld <= 1, last <= winner.
REQ-015 When load_en and no vld set: out_vld <= 0; out_data, out_sel, last unchanged.
REQ-016 When !load_en (out_vld && !out_rdy): out_data, out_sel, out_vld, last held; rdy = 0.
REQ-017 Latency: word accepted in cycle N appears on out_data with out_vld in cycle N+1.
REQ-018 Throughput: one word per cycle with out_rdy held 1; simultaneous drain and load in the same cycle is legal and lossless.
REQ-019 Fairness: a channel holding vld continuously is granted within 4 grants.
REQ-020 vld changes while not granted are legal; no input-side state held.
REQ-021 out_data/out_sel stable whenever out_vld && !out_rdy.

Reset
REQ-022 On rst high at a clock edge: out_vld <= 0, out_data <= 0, out_sel <= 0, last <= 3 (channel 0 highest priority after reset).
REQ-023 rst overrides any transfer in the same cycle; a word held mid-stall is discarded.
REQ-024 rdy = 0 in every cycle where rst is high.

Structure
REQ-025 Shared package arb_mux_pkg holds: typedef for 2-bit channel index, constant NUM_CH = 4, constant RST_LAST = 3.
REQ-026 One sub-module rr_pick_4: combinational, inputs vld[3:0] and last[1:0], outputs winner index and any_vld; arbitration state stays in arb_mux_4_1.
REQ-027 Output register and last pointer are the only sequential state.

Verification
REQ-028 Reset, then vld=4'b0001, d0=4'hA, out_rdy=1 -> rdy=4'b0001 same cycle; next cycle out_vld=1, out_data=4'hA, out_sel=0.
REQ-029 All vld=4'b1111 held, d0..d3=1,2,3,4, out_rdy=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 1,2,3,4,1.
REQ-030 Backpressure: word 4'h5 loaded, out_rdy=0 for 3 cycles while vld=4'b0110 -> rdy=0, out_data=4'h5 held; out_rdy=1 -> rdy=4'b0010 (or the next channel after last), new word next cycle.
REQ-031 Wrap: last=3, vld=4'b1000 only -> grant 3; then vld=4'b1001 -> grant 0 before 3.
REQ-032 rst asserted while out_vld=1 and out_rdy=0 -> next cycle out_vld=0, out_data=0, out_sel=0; first grant after release goes to lowest set vld bit starting at 0.
REQ-033 vld=0 with out_rdy=1 after a valid word -> out_vld drops to 0 next cycle, out_data keeps last value.
